// File: rtl/instr_prog_mem_pkg.sv
// Shared definitions for the SIMD instruction program memory: opcodes,
// the default STOP word and the loader/fetch state encoding.
package simd_instr_pkg;

  localparam logic [2:0] OP_LOADA   = 3'b010;
  localparam logic [2:0] OP_LOADB   = 3'b011;
  localparam logic [2:0] OP_MULTACC = 3'b100;
  localparam logic [2:0] OP_STORE   = 3'b101;
  localparam logic [2:0] OP_STOP    = 3'b110;
  localparam logic [2:0] OP_ADDSUB  = 3'b111;

  // A bare STOP opcode in the low bits; returned for every invalid fetch.
  localparam logic [31:0] STOP_WORD_DEFAULT = {29'd0, OP_STOP};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } pm_state_e;

endpackage

// File: rtl/instr_prog_mem_if.sv
// Load/fetch bus of the instruction program memory. PAR_ERR exists only
// when INSTR_PARITY_EN is defined.
interface instr_prog_mem_if #(
  parameter int DEPTH = 512,
  parameter int IW    = 32
);
  localparam int AW = $clog2(DEPTH);

  logic          LD_CLR;
  logic          LD_VALID;
  logic          LD_READY;
  logic [IW-1:0] LD_DATA;
  logic          LD_LAST;
  logic          FETCH_REQ;
  logic [AW-1:0] PC;
  logic [IW-1:0] INSTR;
  logic          INSTR_VALID;
  logic [AW:0]   PROG_LEN;
  logic          RUN_RDY;
  logic          FETCH_OOR;
`ifdef INSTR_PARITY_EN
  logic          PAR_ERR;
`endif

  modport master (
    output LD_CLR, LD_VALID, LD_DATA, LD_LAST, FETCH_REQ, PC,
`ifdef INSTR_PARITY_EN
    input  PAR_ERR,
`endif
    input  LD_READY, INSTR, INSTR_VALID, PROG_LEN, RUN_RDY, FETCH_OOR
  );

  modport slave (
    input  LD_CLR, LD_VALID, LD_DATA, LD_LAST, FETCH_REQ, PC,
`ifdef INSTR_PARITY_EN
    output PAR_ERR,
`endif
    output LD_READY, INSTR, INSTR_VALID, PROG_LEN, RUN_RDY, FETCH_OOR
  );

endinterface

// File: rtl/instr_prog_mem_bank.sv
// instr_mem_bank: 1R1W synchronous RAM with a registered read port.
// Contents are never reset; visibility is controlled by the owner.
module instr_mem_bank #(
  parameter int DEPTH = 512,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_reg [DEPTH];
  logic [W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem_reg[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/instr_prog_mem.sv
// Instruction program memory: streaming loader, gated single-cycle fetch.
// Optional even-parity protection of stored words via INSTR_PARITY_EN.
module instr_prog_mem
  import simd_instr_pkg::*;
#(
  parameter int            DEPTH     = 512,
  parameter int            IW        = 32,
  parameter logic [IW-1:0] STOP_WORD = IW'(STOP_WORD_DEFAULT)
) (
  input  logic             CLK,
  input  logic             RSTN,
  instr_prog_mem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
`ifdef INSTR_PARITY_EN
  localparam int MW = IW + 1;
`else
  localparam int MW = IW;
`endif

  pm_state_e     state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   prog_len_reg, prog_len_next;
  logic          valid_reg, oor_reg, hit_reg;
  logic          ld_ready, ld_accept, ptr_at_end, fetch_hit, instr_ok;
  logic [MW-1:0] mem_wdata, mem_rdata;

  assign ld_ready   = (state_reg != ST_RUN);
  assign ld_accept  = bus.LD_VALID && ld_ready && !bus.LD_CLR;
  assign ptr_at_end = (wr_ptr_reg == AW'(DEPTH - 1));
  // Only a complete program in RUN is visible, and only below PROG_LEN.
  assign fetch_hit  = bus.FETCH_REQ && !bus.LD_CLR && (state_reg == ST_RUN)
                      && ({1'b0, bus.PC} < prog_len_reg);

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    prog_len_next = prog_len_reg;
    if (bus.LD_CLR) begin
      state_next    = ST_EMPTY;
      wr_ptr_next   = '0;
      prog_len_next = '0;
    end else if (ld_accept) begin
      prog_len_next = prog_len_reg + (AW+1)'(1);
      wr_ptr_next   = ptr_at_end ? wr_ptr_reg : wr_ptr_reg + AW'(1);
      state_next    = (bus.LD_LAST || ptr_at_end) ? ST_RUN : ST_LOAD;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg    <= ST_EMPTY;
      wr_ptr_reg   <= '0;
      prog_len_reg <= '0;
      valid_reg    <= 1'b0;
      oor_reg      <= 1'b0;
      hit_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      prog_len_reg <= prog_len_next;
      valid_reg    <= bus.FETCH_REQ;
      oor_reg      <= bus.FETCH_REQ && !fetch_hit;
      // Output select only moves on a fetch so INSTR holds between fetches.
      if (bus.FETCH_REQ) begin
        hit_reg <= fetch_hit;
      end
    end
  end

`ifdef INSTR_PARITY_EN
  logic par_bad;
  assign mem_wdata   = {^bus.LD_DATA, bus.LD_DATA};
  assign par_bad     = ^mem_rdata;
  assign instr_ok    = hit_reg && !par_bad;
  assign bus.PAR_ERR = valid_reg && hit_reg && par_bad;
`else
  assign mem_wdata   = bus.LD_DATA;
  assign instr_ok    = hit_reg;
`endif

  instr_mem_bank #(
    .DEPTH (DEPTH),
    .W     (MW)
  ) u_bank (
    .clk   (CLK),
    .we    (ld_accept),
    .waddr (wr_ptr_reg),
    .wdata (mem_wdata),
    .re    (fetch_hit),
    .raddr (bus.PC),
    .rdata (mem_rdata)
  );

  assign bus.INSTR       = instr_ok ? mem_rdata[IW-1:0] : STOP_WORD;
  assign bus.INSTR_VALID = valid_reg;
  assign bus.FETCH_OOR   = oor_reg;
  assign bus.RUN_RDY     = (state_reg == ST_RUN);
  assign bus.LD_READY    = ld_ready;
  assign bus.PROG_LEN    = prog_len_reg;

endmodule

// File: tb/tb_instr_prog_mem.sv
// Directed bench for instr_prog_mem with a per-cycle fetch scoreboard.
// Define INSTR_PARITY_EN to also exercise the parity path.
`timescale 1ns/1ps
module tb_instr_prog_mem;

  localparam int            DEPTH = 512;
  localparam int            IW    = 32;
  localparam int            AW    = $clog2(DEPTH);
  localparam logic [IW-1:0] STOP  = 32'h0000_0006;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  instr_prog_mem_if #(.DEPTH(DEPTH), .IW(IW)) bus ();

  instr_prog_mem #(
    .DEPTH     (DEPTH),
    .IW        (IW),
    .STOP_WORD (STOP)
  ) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic          v;
    logic [IW-1:0] instr;
    logic          oor;
    logic          perr;
    string         tag;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  logic [IW-1:0] last_instr = STOP;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: expectation for this cycle's fetch pushed before the edge,
  // popped and compared against the registered outputs after it.
  task automatic cycle(input string tag, input bit fetch = 1'b0,
                       input logic [AW-1:0] pc = '0,
                       input logic [IW-1:0] exp_instr = '0,
                       input bit exp_oor = 1'b0, input bit exp_perr = 1'b0);
    exp_t e;
    bus.FETCH_REQ = fetch;
    bus.PC        = pc;
    e.tag = tag;
    if (fetch) begin
      e.v = 1'b1; e.instr = exp_instr; e.oor = exp_oor; e.perr = exp_perr;
      last_instr = exp_instr;
    end else begin
      e.v = 1'b0; e.instr = last_instr; e.oor = 1'b0; e.perr = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.FETCH_REQ = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "/valid"}, 64'(bus.INSTR_VALID), 64'(e.v));
    chk({e.tag, "/instr"}, 64'(bus.INSTR), 64'(e.instr));
    chk({e.tag, "/oor"}, 64'(bus.FETCH_OOR), 64'(e.oor));
`ifdef INSTR_PARITY_EN
    chk({e.tag, "/perr"}, 64'(bus.PAR_ERR), 64'(e.perr));
`endif
    if (fetch)
      $display("fetch %s pc=%0d instr=%08h valid=%0b oor=%0b", tag, pc, bus.INSTR,
               bus.INSTR_VALID, bus.FETCH_OOR);
  endtask

  task automatic load(input logic [IW-1:0] data, input bit last, input string tag);
    bus.LD_VALID = 1'b1;
    bus.LD_DATA  = data;
    bus.LD_LAST  = last;
    cycle(tag);
    bus.LD_VALID = 1'b0;
    bus.LD_LAST  = 1'b0;
    $display("load %s data=%08h last=%0b prog_len=%0d", tag, data, last, bus.PROG_LEN);
  endtask

  task automatic clear(input string tag);
    bus.LD_CLR = 1'b1;
    cycle(tag);
    bus.LD_CLR = 1'b0;
  endtask

  task automatic chk_status(input string tag, input int len, input bit run);
    chk({tag, "/prog_len"}, 64'(bus.PROG_LEN), 64'(len));
    chk({tag, "/run_rdy"}, 64'(bus.RUN_RDY), 64'(run));
    chk({tag, "/ld_ready"}, 64'(bus.LD_READY), 64'(!run));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.LD_CLR = 1'b0; bus.LD_VALID = 1'b0; bus.LD_DATA = '0; bus.LD_LAST = 1'b0;
    bus.FETCH_REQ = 1'b0; bus.PC = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst/prog_len", 64'(bus.PROG_LEN), 64'd0);
    chk("rst/run_rdy", 64'(bus.RUN_RDY), 64'd0);
    chk("rst/instr", 64'(bus.INSTR), 64'(STOP));
    chk("rst/valid", 64'(bus.INSTR_VALID), 64'd0);
    chk("rst/oor", 64'(bus.FETCH_OOR), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk_status("post_rst", 0, 1'b0);

    // Fetch while EMPTY
    cycle("empty_fetch", 1'b1, AW'(0), STOP, 1'b1);

    // 17-word program
    for (int i = 0; i < 17; i++) load(IW'(32'h100 + i), (i == 16), $sformatf("p17_%0d", i));
    chk_status("p17", 17, 1'b1);

    for (int i = 0; i < 17; i++)
      cycle($sformatf("f%0d", i), 1'b1, AW'(i), IW'(32'h100 + i), 1'b0);
    cycle("hold");
    cycle("oor17", 1'b1, AW'(17), STOP, 1'b1);
    cycle("oor_max", 1'b1, AW'(DEPTH - 1), STOP, 1'b1);
    cycle("oor_idle");

`ifdef INSTR_PARITY_EN
    dut.u_bank.mem_reg[5][0] = ~dut.u_bank.mem_reg[5][0];
    cycle("par5", 1'b1, AW'(5), STOP, 1'b0, 1'b1);
    cycle("par_idle");
    cycle("par4", 1'b1, AW'(4), IW'(32'h104), 1'b0);
`endif

    // Clear with a simultaneous fetch from RUN
    bus.LD_CLR = 1'b1;
    cycle("clr_fetch", 1'b1, AW'(0), STOP, 1'b1);
    bus.LD_CLR = 1'b0;
    chk_status("clr1", 0, 1'b0);

    // Partial load must stay invisible
    for (int i = 0; i < 3; i++) load(IW'(32'h200 + i), 1'b0, $sformatf("part_%0d", i));
    chk_status("part", 3, 1'b0);
    cycle("part_fetch", 1'b1, AW'(0), STOP, 1'b1);

    // Clear wins over a simultaneous load word
    bus.LD_VALID = 1'b1; bus.LD_DATA = 32'hBAD0_BAD0;
    clear("clr_ld");
    bus.LD_VALID = 1'b0;
    chk_status("clr_ld", 0, 1'b0);
    load(32'h300, 1'b1, "one");
    chk_status("one", 1, 1'b1);
    cycle("one_f0", 1'b1, AW'(0), 32'h300, 1'b0);
    cycle("one_f1", 1'b1, AW'(1), STOP, 1'b1);

    // Full memory without LD_LAST
    clear("clr_full");
    for (int i = 0; i < DEPTH; i++) load(IW'(32'h1000 + i), 1'b0, $sformatf("full_%0d", i));
    chk_status("full", DEPTH, 1'b1);
    load(32'hDEAD_BEEF, 1'b0, "extra");
    chk_status("extra", DEPTH, 1'b1);
    cycle("full_last", 1'b1, AW'(DEPTH - 1), IW'(32'h1000 + DEPTH - 1), 1'b0);
    cycle("full_first", 1'b1, AW'(0), 32'h1000, 1'b0);

    // Reset in the middle of a load
    clear("clr_mid");
    for (int i = 0; i < 5; i++) load(IW'(32'h400 + i), 1'b0, $sformatf("mid_%0d", i));
    bus.LD_VALID = 1'b1; bus.LD_DATA = 32'h405;
    #3 rstn = 1'b0;
    #1;
    chk("mid_rst/prog_len", 64'(bus.PROG_LEN), 64'd0);
    chk("mid_rst/run_rdy", 64'(bus.RUN_RDY), 64'd0);
    chk("mid_rst/instr", 64'(bus.INSTR), 64'(STOP));
    chk("mid_rst/valid", 64'(bus.INSTR_VALID), 64'd0);
    bus.LD_VALID = 1'b0;
    last_instr = STOP;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk_status("mid_post", 0, 1'b0);
    load(32'h500, 1'b0, "after_0");
    load(32'h501, 1'b1, "after_1");
    chk_status("after", 2, 1'b1);
    cycle("after_f1", 1'b1, AW'(1), 32'h501, 1'b0);
    cycle("after_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_prog_mem.md
INSTR_PROG_MEM -- requirements
Module: instr_prog_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 512, meaning instruction word count, a power of two of at least 4.
REQ-002 The block SHALL have parameter IW, default 32, meaning instruction width in bits.
REQ-003 The block SHALL have parameter STOP_WORD, default 32'h0000_0006, meaning the STOP instruction returned on any invalid fetch.
REQ-004 Port CLK, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-005 Port RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port LD_CLR, input, 1 bit: a single-cycle pulse that SHALL discard the program and return to EMPTY.
REQ-007 Port LD_VALID, input, 1 bit: the load word is valid.
REQ-008 Port LD_READY, output, 1 bit: the block accepts a load word.
REQ-009 Port LD_DATA, input, IW bits: the load word.
REQ-010 Port LD_LAST, input, 1 bit: marks the final word of the program.
REQ-011 Port FETCH_REQ, input, 1 bit: fetch request.
REQ-012 Port PC, input, $clog2(DEPTH) bits: fetch address.
REQ-013 Port INSTR, output, IW bits: the fetched instruction.
REQ-014 Port INSTR_VALID, output, 1 bit: INSTR is valid this cycle.
REQ-015 Port PROG_LEN, output, $clog2(DEPTH)+1 bits: the number of loaded words.
REQ-016 Port RUN_RDY, output, 1 bit: the program is loaded and executable.
REQ-017 Port FETCH_OOR, output, 1 bit: a single-cycle pulse flagging that the last fetch was beyond PROG_LEN or outside RUN.

Function
REQ-018 The FSM SHALL have the states EMPTY, LOAD and RUN.
REQ-019 In EMPTY, the first accepted load word SHALL be written at address 0, and the FSM SHALL go to LOAD, or to RUN if LD_LAST is set.
REQ-020 A load word SHALL be accepted when LD_VALID and LD_READY are both high on a rising edge; each accepted word SHALL be written at the write pointer, and the pointer and PROG_LEN SHALL then increment.
REQ-021 LD_READY SHALL be high in EMPTY and in LOAD, and SHALL be low in RUN.
REQ-022 In LOAD, when the accepted word has LD_LAST set, or when the word accepted is at address DEPTH-1, the FSM SHALL go to RUN; the pointer SHALL never wrap.
REQ-023 RUN_RDY SHALL be 1 only in RUN.
REQ-024 A fetch SHALL have a latency of exactly 1 cycle: INSTR and INSTR_VALID SHALL be registered and INSTR_VALID SHALL be high in the cycle after FETCH_REQ; back-to-back fetches SHALL give one result per cycle.
REQ-025 When FETCH_REQ is low, INSTR_VALID SHALL go low on the next cycle and INSTR SHALL hold its last value.
REQ-026 On a fetch in RUN with PC < PROG_LEN, INSTR SHALL be the word stored at PC.
REQ-027 On a fetch with PC >= PROG_LEN, or a fetch outside RUN, INSTR SHALL be STOP_WORD, INSTR_VALID SHALL be 1 and FETCH_OOR SHALL pulse.
REQ-028 LD_CLR SHALL take priority over a simultaneous load or fetch: the next state SHALL be EMPTY, PROG_LEN SHALL be 0, and a fetch in the same cycle SHALL return STOP_WORD.
REQ-029 A fetch in LOAD SHALL return STOP_WORD, and SHALL never return a partially loaded program.
REQ-030 Memory contents SHALL not be cleared by LD_CLR or by reset; only PROG_LEN SHALL gate their visibility.

Reset
REQ-031 While RSTN is low, the state SHALL be EMPTY, the pointer and PROG_LEN SHALL be 0, INSTR SHALL be STOP_WORD, and INSTR_VALID, FETCH_OOR and RUN_RDY SHALL be 0.
REQ-032 LD_READY SHALL be 1 after reset is released, as EMPTY requires.
REQ-033 Reset asserted in the middle of a load SHALL abandon the partial program, and PROG_LEN SHALL read 0.

Configuration
REQ-034 The macro INSTR_PARITY_EN SHALL control a parity feature; when it is defined, each stored word SHALL carry one even-parity bit computed at write time.
REQ-035 With INSTR_PARITY_EN defined, the parity SHALL be checked on fetch, and a mismatch SHALL replace INSTR with STOP_WORD and pulse an extra output PAR_ERR (output, 1 bit) alongside INSTR_VALID.
REQ-036 Without INSTR_PARITY_EN, the PAR_ERR port and the parity storage SHALL be absent.

Structure
REQ-037 The package simd_instr_pkg SHALL hold the opcode constants (OP_LOADA=3'b010, OP_LOADB=3'b011, OP_MULTACC=3'b100, OP_STORE=3'b101, OP_STOP=3'b110, OP_ADDSUB=3'b111), the default STOP_WORD, and the FSM state enum.
REQ-038 The block SHALL have one sub-module, instr_mem_bank: a 1R1W synchronous RAM of DEPTH words by (IW plus optional parity) bits, with a registered read.

Verification
REQ-039 The bench SHALL cover this scenario: reset, then load 17 words 0x100..0x110 with LD_LAST on the 17th -> RUN_RDY=1, PROG_LEN=17, LD_READY=0.
REQ-040 The bench SHALL cover this scenario: fetch PC=0..16 back-to-back -> INSTR is 0x100..0x110 one cycle later, INSTR_VALID high continuously.
REQ-041 The bench SHALL cover this scenario: fetch PC=17 and PC=511 -> INSTR=0x00000006, FETCH_OOR pulses once per fetch.
REQ-042 The bench SHALL cover this scenario: load 3 words without LD_LAST, fetch PC=0 -> STOP_WORD with FETCH_OOR; then LD_CLR together with LD_VALID -> word not accepted, PROG_LEN=0, state EMPTY.
REQ-043 The bench SHALL cover this scenario: load DEPTH words without LD_LAST -> RUN entered after word DEPTH-1, PROG_LEN=DEPTH, a further LD_VALID is ignored.
REQ-044 The bench SHALL cover this scenario, with INSTR_PARITY_EN defined: force-flip one stored bit at PC=5, then fetch PC=5 -> INSTR=STOP_WORD, PAR_ERR=1 for one cycle.
